// File: rtl/trc_light_fsm.sv
// trc_light_fsm: two-road traffic light controller with a pedestrian phase.
//
// Ports:
//   clk_50MHz   - single clock
//   rst         - synchronous reset, active-high
//   tick        - timebase strobe; each high cycle counts as one tick
//   side_sensor - side-road vehicle present (level)
//   ped_req     - pedestrian button (level)
//   main_r/y/g  - main-road lamps
//   side_r/y/g  - side-road lamps
//   walk        - pedestrian walk lamp
//   ped_ack     - one-cycle pulse on entry to the walk phase
//   state_o     - current state code
//   remaining   - ticks left in the current state
module trc_light_fsm #(
   parameter int unsigned T_MAIN_G = 10,
   parameter int unsigned T_YEL    = 2,
   parameter int unsigned T_SIDE_G = 6,
   parameter int unsigned T_ALLRED = 1,
   parameter int unsigned T_WALK   = 4
) (
   input  logic       clk_50MHz,
   input  logic       rst,
   input  logic       tick,
   input  logic       side_sensor,
   input  logic       ped_req,
   output logic       main_r,
   output logic       main_y,
   output logic       main_g,
   output logic       side_r,
   output logic       side_y,
   output logic       side_g,
   output logic       walk,
   output logic       ped_ack,
   output logic [2:0] state_o,
   output logic [7:0] remaining
);

   typedef enum logic [2:0] {
      StMainG = 3'd0,
      StMainY = 3'd1,
      StAllR1 = 3'd2,
      StSideG = 3'd3,
      StSideY = 3'd4,
      StAllR2 = 3'd5,
      StWalk  = 3'd6
   } state_e;

   // A zero duration would leave a timed state with nothing to count down.
   localparam logic [7:0] DurMainG = (T_MAIN_G == 0) ? 8'd1 : 8'(T_MAIN_G);
   localparam logic [7:0] DurYel   = (T_YEL    == 0) ? 8'd1 : 8'(T_YEL);
   localparam logic [7:0] DurSideG = (T_SIDE_G == 0) ? 8'd1 : 8'(T_SIDE_G);
   localparam logic [7:0] DurAllR  = (T_ALLRED == 0) ? 8'd1 : 8'(T_ALLRED);
   localparam logic [7:0] DurWalk  = (T_WALK   == 0) ? 8'd1 : 8'(T_WALK);

   state_e     state_q, state_d;
   logic [7:0] rem_q, rem_d;
   logic       pend_q, pend_d;
   logic       ack_q, ack_d;
   logic       adv;
   state_e     nxt;

   function automatic logic [7:0] dur(input state_e s);
      case (s)
         StMainG:          dur = DurMainG;
         StMainY, StSideY: dur = DurYel;
         StSideG:          dur = DurSideG;
         StWalk:           dur = DurWalk;
         default:          dur = DurAllR;
      endcase
   endfunction

   // State register
   always_ff @(posedge clk_50MHz) begin
      if (rst) begin
         state_q <= StMainG;
         rem_q   <= DurMainG;
         pend_q  <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         pend_q  <= pend_d;
         ack_q   <= ack_d;
      end
   end

   // Next-state logic
   always_comb begin
      adv     = 1'b0;
      nxt     = StMainG;
      state_d = state_q;
      rem_d   = rem_q;
      ack_d   = 1'b0;
      // Requests are latched everywhere except while already walking.
      pend_d  = pend_q | (ped_req & (state_q != StWalk));

      case (state_q)
         StMainG: begin
            // Green minimum counts down to 0, then waits for demand without a tick.
            if (rem_q == 8'd0) begin
               if (side_sensor || pend_q) begin
                  adv = 1'b1;
                  nxt = StMainY;
               end
            end else if (tick) begin
               rem_d = rem_q - 8'd1;
            end
         end
         StMainY, StAllR1, StSideG, StSideY, StAllR2, StWalk: begin
            if (tick) begin
               if (rem_q <= 8'd1) begin
                  adv = 1'b1;
                  case (state_q)
                     StMainY: nxt = StAllR1;
                     StAllR1: nxt = pend_q ? StWalk : StSideG;
                     StSideG: nxt = StSideY;
                     StSideY: nxt = StAllR2;
                     StWalk:  nxt = StAllR2;
                     default: nxt = StMainG;
                  endcase
               end else begin
                  rem_d = rem_q - 8'd1;
               end
            end
         end
         default: begin
            // Illegal code: recover to main green.
            adv = 1'b1;
            nxt = StMainG;
         end
      endcase

      if (adv) begin
         state_d = nxt;
         rem_d   = dur(nxt);
         if (nxt == StWalk) begin
            // Clearing on walk entry wins over a request in the same cycle.
            pend_d = 1'b0;
            ack_d  = 1'b1;
         end
      end
   end

   // Moore output decode
   always_comb begin
      main_r = 1'b0;
      main_y = 1'b0;
      main_g = 1'b0;
      side_r = 1'b0;
      side_y = 1'b0;
      side_g = 1'b0;
      walk   = 1'b0;
      case (state_q)
         StMainG: begin
            main_g = 1'b1;
            side_r = 1'b1;
         end
         StMainY: begin
            main_y = 1'b1;
            side_r = 1'b1;
         end
         StSideG: begin
            side_g = 1'b1;
            main_r = 1'b1;
         end
         StSideY: begin
            side_y = 1'b1;
            main_r = 1'b1;
         end
         StWalk: begin
            main_r = 1'b1;
            side_r = 1'b1;
            walk   = 1'b1;
         end
         default: begin
            main_r = 1'b1;
            side_r = 1'b1;
         end
      endcase
   end

   assign ped_ack   = ack_q;
   assign state_o   = state_q;
   assign remaining = rem_q;

endmodule
